// File: rtl/div_ctrl.sv
// Sequencing controller between EX and the iterative 32-bit divider: latches
// operands, runs the start/annul handshake, stalls EX and writes HI/LO once.
module div_ctrl #(
    parameter int CANCEL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int CNT_W = $clog2(CANCEL_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_CANCEL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // A flush always beats both a new request and a same-cycle divider result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (ex_div_valid_i && !flush_i) begin
                    signed_d = ex_signed_i;
                    op1_d    = ex_op1_i;
                    op2_d    = ex_op2_i;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    cnt_d   = CNT_W'(CANCEL_CYCLES - 1);
                    state_d = S_CANCEL;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_CANCEL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dropping start in DONE/CANCEL is what returns the divider to its free state.
    always_comb begin
        stall_o     = 1'b0;
        hilo_we_o   = 1'b0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_o = ex_div_valid_i && !flush_i;
            end
            S_BUSY: begin
                stall_o     = 1'b1;
                div_start_o = 1'b1;
            end
            S_DONE: begin
                hilo_we_o = !flush_i;
            end
            S_CANCEL: begin
                div_annul_o = 1'b1;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider with fixed latency plus directed and
// randomized divides checked against plain integer arithmetic.
module tb_div_ctrl;

    localparam int CANCEL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_signed_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        flush_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    int checks = 0;
    int fails  = 0;

    div_ctrl #(.CANCEL_CYCLES(CANCEL_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .ex_div_valid_i(ex_div_valid_i),
        .ex_signed_i(ex_signed_i),
        .ex_op1_i(ex_op1_i),
        .ex_op2_i(ex_op2_i),
        .flush_i(flush_i),
        .stall_o(stall_o),
        .hilo_we_o(hilo_we_o),
        .hi_o(hi_o),
        .lo_o(lo_o),
        .div_start_o(div_start_o),
        .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o),
        .div_op2_o(div_op2_o),
        .div_result_i(div_result_i),
        .div_ready_i(div_ready_i)
    );

    always #5 clk = ~clk;

    // {remainder, quotient}; signed division truncates toward zero, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: ready after 35 cycles of start (3 for divide by zero), once per start.
    int unsigned dcnt;
    bit          ddone;
    always @(posedge clk) begin
        if (rst || !div_start_o) begin
            dcnt  <= 0;
            ddone <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            if (div_ready_i) ddone <= 1'b1;
        end
    end
    assign div_ready_i  = div_start_o && !ddone && (dcnt == ((div_op2_o == 32'd0) ? 32'd3 : 32'd35));
    assign div_result_i = div_ready_i ? ref_div(div_signed_o, div_op1_o, div_op2_o) : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One divide; fl = cycle (relative to accept) at which flush_i is raised, or -1.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int fl);
        int lat, r_cyc, d_cyc, last;
        bit cancel_path;
        logic [63:0] exp;
        logic [31:0] hi_prev, lo_prev;
        lat   = (b == 32'd0) ? 3 : 35;
        r_cyc = lat + 1;
        d_cyc = r_cyc + 1;
        cancel_path = (fl >= 1) && (fl <= r_cyc);
        last  = cancel_path ? fl + CANCEL_CYCLES : d_cyc;
        exp   = ref_div(sgn, a, b);
        @(posedge clk); #1;
        hi_prev = hi_o;
        lo_prev = lo_o;
        ex_div_valid_i = 1'b1;
        ex_signed_i    = sgn;
        ex_op1_i       = a;
        ex_op2_i       = b;
        flush_i        = 1'b0;
        #1;
        chk("accept_stall", stall_o, 1);
        chk("accept_annul", div_annul_o, 0);
        chk("accept_hilo_we", hilo_we_o, 0);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            flush_i = (c == fl);
            if (c <= r_cyc && !(cancel_path && c > fl)) begin
                ex_op1_i    = $urandom;
                ex_op2_i    = $urandom;
                ex_signed_i = 1'($urandom);
                #1;
                chk("busy_stall", stall_o, 1);
                chk("busy_start", div_start_o, 1);
                chk("busy_hilo_we", hilo_we_o, 0);
                if (c == 1 || c == r_cyc) begin
                    chk("busy_op1", div_op1_o, a);
                    chk("busy_op2", div_op2_o, b);
                    chk("busy_signed", div_signed_o, sgn);
                end
            end else if (cancel_path) begin
                ex_div_valid_i = 1'b0;
                #1;
                chk("cancel_annul", div_annul_o, 1);
                chk("cancel_start", div_start_o, 0);
                chk("cancel_stall", stall_o, 0);
                chk("cancel_hilo_we", hilo_we_o, 0);
                chk("cancel_hi_hold", hi_o, hi_prev);
                chk("cancel_lo_hold", lo_o, lo_prev);
            end else begin
                ex_div_valid_i = 1'b0;
                #1;
                chk("done_hilo_we", hilo_we_o, (fl == d_cyc) ? 0 : 1);
                chk("done_stall", stall_o, 0);
                chk("done_start", div_start_o, 0);
                chk("done_annul", div_annul_o, 0);
                chk("done_hi", hi_o, exp[63:32]);
                chk("done_lo", lo_o, exp[31:0]);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_hilo_we"}, hilo_we_o, 0);
        chk({tag, "_hi"}, hi_o, 0);
        chk({tag, "_lo"}, lo_o, 0);
        chk({tag, "_start"}, div_start_o, 0);
        chk({tag, "_annul"}, div_annul_o, 0);
        chk({tag, "_signed"}, div_signed_o, 0);
        chk({tag, "_op1"}, div_op1_o, 0);
        chk({tag, "_op2"}, div_op2_o, 0);
    endtask

    task automatic run_reset_mid(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        ex_div_valid_i = 1'b1;
        ex_signed_i    = sgn;
        ex_op1_i       = a;
        ex_op2_i       = b;
        flush_i        = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        rst            = 1'b1;
        ex_div_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            chk("midrst_hilo_we", hilo_we_o, 0);
        end
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        rst            = 1'b1;
        ex_div_valid_i = 1'b0;
        ex_signed_i    = 1'b0;
        ex_op1_i       = 32'd0;
        ex_op2_i       = 32'd0;
        flush_i        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, -1);
        chk("u100_7_lo", lo_o, 32'd14);
        chk("u100_7_hi", hi_o, 32'd2);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        chk("s_m7_2_lo", lo_o, 32'hFFFF_FFFD);
        chk("s_m7_2_hi", hi_o, 32'hFFFF_FFFF);

        run_div(1'b0, 32'd5, 32'd0, -1);
        chk("dz_lo", lo_o, 32'd0);
        chk("dz_hi", hi_o, 32'd0);
        run_div(1'b0, 32'd9, 32'd3, -1);
        chk("u9_3_lo", lo_o, 32'd3);
        chk("u9_3_hi", hi_o, 32'd0);

        run_div(1'b0, 32'd1234, 32'd5, 10);
        run_div(1'b0, 32'd20, 32'd6, -1);
        chk("u20_6_lo", lo_o, 32'd3);
        chk("u20_6_hi", hi_o, 32'd2);

        run_div(1'b0, 32'd77, 32'd4, 36);
        run_div(1'b1, 32'hFFFF_FF00, 32'd3, 37);
        run_div(1'b0, 32'd50, 32'd0, 4);

        run_reset_mid(1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, -1);
        chk("s_m100_7_lo", lo_o, 32'hFFFF_FFF2);
        chk("s_m100_7_hi", hi_o, 32'hFFFF_FFFE);

        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            if (i % 4 == 0) b = 32'd0;
            else if (i % 4 == 1) b = $urandom;
            else b = $urandom_range(1, 1000);
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            run_div(sgn, a, b, (i == 5) ? int'($urandom_range(1, 30)) : -1);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the execute stage and the iterative 32-bit divider. It accepts DIV/DIVU requests from EX, latches their operands, drives the divider's start/annul handshake, stalls the pipeline while the divider runs, and emits a one-cycle HI/LO write with the 64-bit result. It also cleanly cancels an in-flight divide on pipeline flush, leaving the divider in its free state.

## Interface
- CANCEL_CYCLES, 2, number of cycles the block holds start low and annul high after a flush. Must be at least 2 to cover the divider's divide-by-zero path.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. The divider shares this reset.
- ex_div_valid_i  in  1  EX holds a DIV/DIVU instruction.
- ex_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- ex_op1_i  in  32  dividend.
- ex_op2_i  in  32  divisor.
- flush_i  in  1  pipeline flush (exception or branch squash) of the EX instruction.
- stall_o  out  1  holds the pipeline at EX and earlier stages.
- hilo_we_o  out  1  one-cycle HI/LO write strobe.
- hi_o  out  32  remainder, valid with hilo_we_o.
- lo_o  out  32  quotient, valid with hilo_we_o.
- div_start_o  out  1  divider start. Held high for the whole operation.
- div_annul_o  out  1  divider abort.
- div_signed_o  out  1  latched signed flag to the divider.
- div_op1_o  out  32  latched dividend.
- div_op2_o  out  32  latched divisor.
- div_result_i  in  64  divider result, {remainder, quotient}.
- div_ready_i  in  1  divider result valid.

## Operation
States: IDLE, BUSY, DONE, CANCEL.
- IDLE
  - ex_div_valid_i=1 and flush_i=0: latch signed flag and both operands, then go to BUSY.
  - stall_o=1 combinationally in this accept cycle.
  - flush_i=1 wins over a request: nothing is latched and the state stays IDLE.
- BUSY
  - Outputs: div_start_o=1, stall_o=1, div_* driven from the latched registers.
  - div_ready_i=1: register div_result_i into hi/lo, then go to DONE.
  - flush_i=1: go to CANCEL. This has priority over div_ready_i in the same cycle; the result is discarded.
- DONE (one cycle)
  - Outputs: hilo_we_o=1 (forced to 0 if flush_i=1 this cycle), stall_o=0, div_start_o=0.
  - div_start_o=0 here returns the divider from its end state to free.
  - Next state: IDLE.
- CANCEL
  - Outputs: div_start_o=0, div_annul_o=1, stall_o=0, hilo_we_o=0.
  - Held for CANCEL_CYCLES cycles using a down-counter, then go to IDLE.
- Other cycles: div_annul_o=0. hi_o/lo_o hold their last registered value.
- Divide by zero: the block does not special-case it. The divider returns {0,0}, and HI=LO=0 is written.
- Sign handling, magnitude conversion and remainder sign are done entirely by the divider. The block passes div_result_i through unmodified: hi_o = result[63:32], lo_o = result[31:0].
- Latched operands do not change from accept until the controller leaves BUSY, even if the ex_* inputs change.

## Timing
- Reset values: state IDLE, stall_o=0, hilo_we_o=0, hi_o=0, lo_o=0, div_start_o=0, div_annul_o=0, div_signed_o=0, div_op1_o=0, div_op2_o=0, cancel counter 0.
- Normal divide, with the request accepted in cycle 0:
  - div_start_o is high from cycle 1.
  - div_ready_i is seen in cycle 36.
  - hilo_we_o is asserted in cycle 37.
  - stall_o is high in cycles 0–36.
- Divide by zero: div_ready_i in cycle 4, hilo_we_o in cycle 5.
- Back-to-back: a new request is accepted in the first IDLE cycle after DONE. There is no idle bubble beyond DONE.
- Reset mid-operation: the block returns to IDLE next cycle with all outputs at reset values, and no hilo_we_o is issued.
- hilo_we_o is never asserted for two consecutive cycles.

## Test plan
- Unsigned 100 / 7 → hilo_we_o in cycle 37 with LO=14, HI=2; stall_o high in cycles 0–36 only.
- Signed -7 / 2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero, 5 / 0 → hilo_we_o in cycle 5, HI=LO=0; a following 9 / 3 → LO=3, HI=0.
- flush_i at cycle 10 of a divide → div_annul_o high for 2 cycles, no hilo_we_o, IDLE after that; the next 20 / 6 → LO=3, HI=2.
- flush_i in the same cycle as div_ready_i, and separately in DONE → hilo_we_o stays 0.
- rst asserted at cycle 15 → all outputs at reset values next cycle; the next divide completes correctly.
